seq_divider: RTL and testbench

SEQ_DIVIDER -- requirements
Module: seq_divider

---
 rtl/div_pkg.sv | 5 +
 rtl/seq_divider_adder.sv | 15 +
 rtl/seq_divider.sv | 142 ++++++++++++++
 tb/tb_seq_divider.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// div_pkg: shared FSM state type and default operand width for seq_divider.
package div_pkg;
    localparam int DIV_WIDTH = 32;
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
endpackage

// File: rtl/seq_divider_adder.sv
// seq_divider_adder: W-bit scalar adder; C_in=1 turns it into A-B with C_flag reporting borrow.
module seq_divider_adder #(
    parameter int W = 33
) (
    input  logic [W-1:0] A,
    input  logic [W-1:0] B,
    input  logic         C_in,
    output logic [W-1:0] S,
    output logic         C_flag
);
    logic [W:0] w_sum;
    assign w_sum  = {1'b0, A} + {1'b0, C_in ? ~B : B} + {{W{1'b0}}, C_in};
    assign S      = w_sum[W-1:0];
    assign C_flag = w_sum[W] ^ C_in;
endmodule

// File: rtl/seq_divider.sv
// seq_divider: radix-2 restoring sequential divider, one quotient bit per cycle, N+2 cycles per op.
// Define DIV_SIGNED_EN to add the signed_op port and two's-complement division.
module seq_divider
    import div_pkg::*;
#(
    parameter int N = DIV_WIDTH
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
`ifdef DIV_SIGNED_EN
    input  logic         signed_op,
`endif
    output logic         busy,
    output logic         done,
    output logic [N-1:0] Q,
    output logic [N-1:0] R,
    output logic         Z_flag,
    output logic         DZ_flag,
    output logic         V_flag
);
    localparam int CW = $clog2(N) + 1;

    state_t        r_state;
    logic [CW-1:0] r_cnt;
    logic [N:0]    r_rem;
    logic [N-1:0]  r_quo;
    logic [N-1:0]  r_div;
    logic          r_neg_q;
    logic          r_neg_r;
    logic          r_ovf;

    logic          w_sa;
    logic          w_sb;
    logic [N-1:0]  w_mag_a;
    logic [N-1:0]  w_mag_b;
    logic          w_ovf;
    logic [N:0]    w_shift;
    logic [N:0]    w_trial;
    logic          w_borrow;
    logic [N:0]    w_rem_next;
    logic [N-1:0]  w_quo_next;
    logic [N-1:0]  w_q_fin;
    logic [N-1:0]  w_r_fin;
    logic          w_unused_rem_msb;

`ifdef DIV_SIGNED_EN
    assign w_sa = signed_op & A[N-1];
    assign w_sb = signed_op & B[N-1];
`else
    assign w_sa = 1'b0;
    assign w_sb = 1'b0;
`endif
    assign w_mag_a = w_sa ? -A : A;
    assign w_mag_b = w_sb ? -B : B;
    // Most-negative / -1: the magnitude quotient 2^(N-1) is already the wrapped answer.
    assign w_ovf   = w_sa & w_sb & ~|A[N-2:0] & &B;

    // The restored remainder is always below the divisor, so its top bit never reaches the shift.
    assign w_unused_rem_msb = r_rem[N];
    assign w_shift          = {r_rem[N-1:0], r_quo[N-1]};

    seq_divider_adder #(.W(N + 1)) u_sub (
        .A      (w_shift),
        .B      ({1'b0, r_div}),
        .C_in   (1'b1),
        .S      (w_trial),
        .C_flag (w_borrow)
    );

    assign w_rem_next = w_borrow ? w_shift : w_trial;
    assign w_quo_next = {r_quo[N-2:0], ~w_borrow};
    assign w_q_fin    = r_neg_q ? -w_quo_next : w_quo_next;
    assign w_r_fin    = r_neg_r ? -w_rem_next[N-1:0] : w_rem_next[N-1:0];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_rem   <= '0;
            r_quo   <= '0;
            r_div   <= '0;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
            r_ovf   <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            Q       <= '0;
            R       <= '0;
            Z_flag  <= 1'b0;
            DZ_flag <= 1'b0;
            V_flag  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start && B == '0) begin
                        Q       <= '1;
                        R       <= A;
                        Z_flag  <= 1'b0;
                        DZ_flag <= 1'b1;
                        V_flag  <= 1'b0;
                        busy    <= 1'b1;
                        done    <= 1'b1;
                        r_state <= DONE;
                    end else if (start) begin
                        r_rem   <= '0;
                        r_quo   <= w_mag_a;
                        r_div   <= w_mag_b;
                        r_neg_q <= w_sa ^ w_sb;
                        r_neg_r <= w_sa;
                        r_ovf   <= w_ovf;
                        r_cnt   <= '0;
                        busy    <= 1'b1;
                        r_state <= CALC;
                    end
                end
                CALC: begin
                    r_rem <= w_rem_next;
                    r_quo <= w_quo_next;
                    r_cnt <= r_cnt + CW'(1);
                    if (r_cnt == CW'(N - 1)) begin
                        Q       <= w_q_fin;
                        R       <= w_r_fin;
                        Z_flag  <= w_q_fin == '0;
                        DZ_flag <= 1'b0;
                        V_flag  <= r_ovf;
                        done    <= 1'b1;
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    busy    <= 1'b0;
                    done    <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: directed-vector bench for seq_divider (N=32); signed vectors with DIV_SIGNED_EN.
module tb_seq_divider;
    logic        clk;
    logic        rst_n;
    logic        start;
    logic [31:0] a;
    logic [31:0] b;
    logic        sop;
    logic        busy;
    logic        done;
    logic [31:0] q;
    logic [31:0] r;
    logic        z_flag;
    logic        dz_flag;
    logic        v_flag;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] q;
        logic [31:0] r;
        logic        sop;
        logic        z;
        logic        dz;
        logic        v;
    } vec_t;

    vec_t vecs[16];
    int   nv;

    seq_divider dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .A         (a),
        .B         (b),
`ifdef DIV_SIGNED_EN
        .signed_op (sop),
`endif
        .busy      (busy),
        .done      (done),
        .Q         (q),
        .R         (r),
        .Z_flag    (z_flag),
        .DZ_flag   (dz_flag),
        .V_flag    (v_flag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Returns the sample index (1 = just after the accepting edge) at which done was seen.
    task automatic run_div(input logic [31:0] ia, input logic [31:0] ib, input logic isop,
                           input int poke_at, output int cyc);
        @(negedge clk);
        a = ia;
        b = ib;
        sop = isop;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        cyc = 1;
        while (!done && cyc < 100) begin
            if (cyc == poke_at) begin
                a = 32'd1;
                b = 32'd1;
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        start = 1'b0;
    endtask

    initial begin
        int cyc;
        int n_done;
        logic [31:0] q_hold;
        rst_n = 1'b0;
        start = 1'b0;
        a = '0;
        b = '0;
        sop = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_q", 64'(q), 64'd0);
        check("rst_r", 64'(r), 64'd0);
        check("rst_flags", 64'({z_flag, dz_flag, v_flag}), 64'd0);
        rst_n = 1'b1;

        nv = 0;
        vecs[nv++] = '{32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[nv++] = '{32'd5, 32'd0, 32'hFFFFFFFF, 32'd5, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[nv++] = '{32'd3, 32'd5, 32'd0, 32'd3, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[nv++] = '{32'hFFFFFFFF, 32'd1, 32'hFFFFFFFF, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[nv++] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'd1, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[nv++] = '{32'd0, 32'd3, 32'd0, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[nv++] = '{32'd1000, 32'd10, 32'd100, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[nv++] = '{32'h80000000, 32'hFFFFFFFF, 32'd0, 32'h80000000, 1'b0, 1'b1, 1'b0, 1'b0};
`ifdef DIV_SIGNED_EN
        vecs[nv++] = '{32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[nv++] = '{32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[nv++] = '{32'd7, 32'hFFFFFFFE, 32'hFFFFFFFD, 32'd1, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[nv++] = '{32'hFFFFFFF8, 32'hFFFFFFFD, 32'd2, 32'hFFFFFFFE, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[nv++] = '{32'hFFFFFFFB, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFB, 1'b1, 1'b0, 1'b1, 1'b0};
`endif

        // Each vector starts in the first IDLE cycle after the previous DONE.
        for (int i = 0; i < nv; i++) begin
            run_div(vecs[i].a, vecs[i].b, vecs[i].sop, -1, cyc);
            check($sformatf("v%0d_cycle", i), 64'(cyc), (vecs[i].b == 0) ? 64'd1 : 64'd33);
            check($sformatf("v%0d_q", i), 64'(q), 64'(vecs[i].q));
            check($sformatf("v%0d_r", i), 64'(r), 64'(vecs[i].r));
            check($sformatf("v%0d_zdzv", i), 64'({z_flag, dz_flag, v_flag}),
                  64'({vecs[i].z, vecs[i].dz, vecs[i].v}));
            check($sformatf("v%0d_busy", i), 64'(busy), 64'd1);
            @(posedge clk);
            #1;
            check($sformatf("v%0d_done_pulse", i), 64'({done, busy}), 64'd0);
            check($sformatf("v%0d_q_hold", i), 64'(q), 64'(vecs[i].q));
        end

        run_div(32'd100, 32'd7, 1'b0, 5, cyc);
        check("ign_cycle", 64'(cyc), 64'd33);
        check("ign_q", 64'(q), 64'd14);
        check("ign_r", 64'(r), 64'd2);
        @(posedge clk);
        #1;

        q_hold = q;
        check("pre_rst_q", 64'(q_hold), 64'd14);
        @(negedge clk);
        a = 32'd100;
        b = 32'd7;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (9) begin
            @(posedge clk);
            #1;
        end
        check("mid_busy", 64'(busy), 64'd1);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_q", 64'(q), 64'd0);
        check("abort_r", 64'(r), 64'd0);
        n_done = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done) n_done++;
        end
        check("abort_no_done", 64'(n_done), 64'd0);

        run_div(32'd50, 32'd6, 1'b0, -1, cyc);
        check("recover_cycle", 64'(cyc), 64'd33);
        check("recover_q", 64'(q), 64'd8);
        check("recover_r", 64'(r), 64'd2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
